// File: rtl/cnn_stream_pkg.sv
// Defaults shared by the CNN streaming stages (line buffer, data register, stream_tx).
package cnn_stream_pkg;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 16;
  localparam int DEFAULT_LINE_LEN   = 512;

  // Index width that never collapses to zero bits for degenerate sizes.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction
endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x DATA_WIDTH register array with one write port, one read port and wrapping pointers.
module stream_fifo_mem
  import cnn_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data
);
  localparam int PTR_W = clog2_min1(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (i_wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (i_rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en && !i_rst) mem[wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = mem[rd_ptr];
endmodule

// File: rtl/stream_tx.sv
// Pixel stream transmit buffer: no-backpressure producer in, valid/ready consumer out,
// with almost-full throttle hint, sticky overflow flag and end-of-line marker.
module stream_tx
  import cnn_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int LINE_LEN     = DEFAULT_LINE_LEN,
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  output logic                  o_almost_full,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  input  logic                  i_data_ready,
  output logic                  o_last,
  output logic                  o_overflow
);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int COL_W = clog2_min1(LINE_LEN);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_LEN - 1);

  logic [OCC_W-1:0]      occupancy;
  logic [OCC_W-1:0]      occ_next;
  logic [COL_W-1:0]      col;
  logic                  transfer;
  logic                  wr_en;
  logic                  drop;
  logic [DATA_WIDTH-1:0] rd_data;

  // Handshake: a word moves downstream in any cycle where o_data_valid and
  // i_data_ready are both high; o_data/o_last hold until that happens.
  // Upstream has no ready: a word offered while full with no transfer is lost.
  assign o_data_valid = (occupancy != '0);
  assign transfer     = o_data_valid && i_data_ready;
  assign wr_en        = i_data_valid && ((occupancy != OCC_W'(DEPTH)) || transfer);
  assign drop         = i_data_valid && !wr_en;

  always_comb begin
    occ_next = occupancy;
    if (wr_en && !transfer)      occ_next = occupancy + OCC_W'(1);
    else if (transfer && !wr_en) occ_next = occupancy - OCC_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      occupancy     <= '0;
      col           <= '0;
      o_almost_full <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      occupancy     <= occ_next;
      o_almost_full <= (occ_next >= OCC_W'(AFULL_THRESH));
      if (drop) o_overflow <= 1'b1;
      if (transfer) col <= (col == LAST_COL) ? '0 : col + COL_W'(1);
    end
  end

  stream_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wr_en  (wr_en),
    .i_wr_data(i_data),
    .i_rd_en  (transfer),
    .o_rd_data(rd_data)
  );

  // Empty slots are never exposed, so o_data reads as zero whenever nothing is held.
  assign o_data = o_data_valid ? rd_data : '0;
  assign o_last = o_data_valid && (col == LAST_COL);
endmodule

// File: tb/tb_stream_tx.sv
// Self-checking bench for stream_tx: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_stream_tx;
  localparam int DW       = 8;
  localparam int DEPTH    = 16;
  localparam int LINE_LEN = 512;
  localparam int AFULL    = DEPTH - 4;

  // ---------------- clock / reset / DUT ----------------
  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [DW-1:0] i_data = '0;
  logic          i_data_valid = 1'b0;
  logic          i_data_ready = 1'b0;
  logic          o_almost_full;
  logic [DW-1:0] o_data;
  logic          o_data_valid;
  logic          o_last;
  logic          o_overflow;

  always #5 i_clk = ~i_clk;

  stream_tx #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .LINE_LEN    (LINE_LEN),
    .AFULL_THRESH(AFULL)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_almost_full(o_almost_full),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_data_ready (i_data_ready),
    .o_last       (o_last),
    .o_overflow   (o_overflow)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];     // words the block should currently hold, head first
  int            m_col = 0;
  bit            m_ovf = 1'b0;
  bit            model_on = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_exp_data = '0;
  bit            prev_exp_last = 1'b0;

  logic [DW-1:0] got_q[$];     // words actually transferred by the DUT
  int            xfer_count = 0;
  int            last_idx[$];  // transfer ordinals on which the DUT showed o_last

  bit            s_valid, s_last, s_afull, s_ovf;
  logic [DW-1:0] s_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare outputs with the model, then advance the model.
  task automatic cycle(input bit rst, input bit dv, input logic [DW-1:0] d, input bit rdy);
    bit            e_valid, e_last, xfer, wr;
    logic [DW-1:0] e_data;
    @(negedge i_clk);
    i_rst = rst;
    i_data_valid = dv;
    i_data = d;
    i_data_ready = rdy;
    #1;
    s_valid = o_data_valid;
    s_data  = o_data;
    s_last  = o_last;
    s_afull = o_almost_full;
    s_ovf   = o_overflow;
    e_valid = (exp_q.size() > 0);
    e_data  = e_valid ? exp_q[0] : '0;
    e_last  = e_valid && (m_col == LINE_LEN - 1);
    if (model_on) begin
      check("model_valid", s_valid, e_valid);
      if (e_valid) check("model_data", s_data, e_data);
      check("model_last", s_last, e_last);
      check("model_afull", s_afull, exp_q.size() >= AFULL);
      check("model_ovf", s_ovf, m_ovf);
      if (prev_stall) begin
        check("stall_data", s_data, prev_exp_data);
        check("stall_last", s_last, prev_exp_last);
      end
    end
    @(posedge i_clk);
    if (!rst && s_valid && rdy) begin
      xfer_count++;
      got_q.push_back(s_data);
      if (s_last) last_idx.push_back(xfer_count);
    end
    if (rst) begin
      exp_q.delete();
      m_col = 0;
      m_ovf = 1'b0;
      model_on = 1'b1;
      prev_stall = 1'b0;
    end else if (model_on) begin
      xfer = e_valid && rdy;
      wr = dv && ((exp_q.size() < DEPTH) || xfer);
      if (dv && !wr) m_ovf = 1'b1;
      if (xfer) begin
        void'(exp_q.pop_front());
        m_col = (m_col + 1) % LINE_LEN;
      end
      if (wr) exp_q.push_back(d);
      prev_stall = e_valid && !rdy;
      prev_exp_data = e_data;
      prev_exp_last = e_last;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst;
    bit          dv;
    logic [7:0]  d;
    bit          rdy;
    bit          e_valid;
    logic [7:0]  e_data;
    bit          e_afull;
    bit          e_ovf;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // three-word pass-through, then five held words, reset with write+transfer, refill
    vecs[0]  = '{0, 1, 8'h11, 1, 0, 8'h00, 0, 0};
    vecs[1]  = '{0, 1, 8'h22, 1, 1, 8'h11, 0, 0};
    vecs[2]  = '{0, 1, 8'h33, 1, 1, 8'h22, 0, 0};
    vecs[3]  = '{0, 0, 8'h00, 1, 1, 8'h33, 0, 0};
    vecs[4]  = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 0};
    vecs[5]  = '{0, 1, 8'hA0, 0, 0, 8'h00, 0, 0};
    vecs[6]  = '{0, 1, 8'hA1, 0, 1, 8'hA0, 0, 0};
    vecs[7]  = '{0, 1, 8'hA2, 0, 1, 8'hA0, 0, 0};
    vecs[8]  = '{0, 1, 8'hA3, 0, 1, 8'hA0, 0, 0};
    vecs[9]  = '{0, 1, 8'hA4, 0, 1, 8'hA0, 0, 0};
    vecs[10] = '{1, 1, 8'hFF, 1, 1, 8'hA0, 0, 0};
    vecs[11] = '{0, 1, 8'hA5, 0, 0, 8'h00, 0, 0};
    vecs[12] = '{0, 0, 8'h00, 1, 1, 8'hA5, 0, 0};
    vecs[13] = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 0};

    // reset state
    cycle(1, 0, '0, 0);
    cycle(1, 0, '0, 0);
    cycle(0, 0, '0, 0);
    check("reset_valid", s_valid, 0);
    check("reset_data", s_data, 0);
    check("reset_last", s_last, 0);
    check("reset_afull", s_afull, 0);
    check("reset_ovf", s_ovf, 0);

    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].rst, vecs[i].dv, vecs[i].d, vecs[i].rdy);
      check($sformatf("vec%0d_valid", i), s_valid, vecs[i].e_valid);
      if (vecs[i].e_valid) check($sformatf("vec%0d_data", i), s_data, vecs[i].e_data);
      check($sformatf("vec%0d_afull", i), s_afull, vecs[i].e_afull);
      check($sformatf("vec%0d_ovf", i), s_ovf, vecs[i].e_ovf);
    end

    // fill past capacity with the consumer stalled
    cycle(1, 0, '0, 0);
    for (int i = 1; i <= 20; i++) begin
      cycle(0, 1, DW'(i), 0);
      if (i == 12) check("afull_at_occ11", s_afull, 0);
      if (i == 13) check("afull_at_occ12", s_afull, 1);
    end
    cycle(0, 0, '0, 0);
    check("overflow_set", s_ovf, 1);
    check("afull_when_full", s_afull, 1);
    got_q.delete();
    for (int i = 0; i < 20; i++) cycle(0, 0, '0, 1);
    check("drain_count", got_q.size(), 16);
    for (int i = 0; i < got_q.size() && i < 16; i++)
      check($sformatf("drain_word%0d", i + 1), got_q[i], i + 1);
    check("overflow_sticky", s_ovf, 1);
    check("drained_valid", s_valid, 0);

    // full with simultaneous write and transfer
    cycle(1, 0, '0, 0);
    for (int i = 1; i <= 16; i++) cycle(0, 1, DW'(i), 0);
    got_q.delete();
    cycle(0, 1, 8'h77, 1);
    cycle(0, 0, '0, 0);
    check("full_wr_xfer_ovf", s_ovf, 0);
    check("full_wr_xfer_afull", s_afull, 1);
    for (int i = 0; i < 20; i++) cycle(0, 0, '0, 1);
    check("full_wr_xfer_count", got_q.size(), 17);
    if (got_q.size() == 17) begin
      check("full_wr_xfer_first", got_q[0], 1);
      check("full_wr_xfer_sixteenth", got_q[15], 16);
      check("full_wr_xfer_tail", got_q[16], 8'h77);
    end

    // long stream for line markers
    cycle(1, 0, '0, 0);
    xfer_count = 0;
    last_idx.delete();
    for (int i = 0; i < 1030; i++) cycle(0, 1, DW'($urandom), 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1);
    check("stream_xfer_count", xfer_count, 1030);
    check("stream_last_count", last_idx.size(), 2);
    if (last_idx.size() >= 2) begin
      check("stream_last_first", last_idx[0], 512);
      check("stream_last_second", last_idx[1], 1024);
    end

    // random producer and random backpressure
    cycle(1, 0, '0, 0);
    for (int i = 0; i < 800; i++)
      cycle(0, $urandom_range(0, 99) < 60, DW'($urandom), $urandom_range(0, 99) < 45);
    for (int i = 0; i < DEPTH + 4; i++) cycle(0, 0, '0, 1);
    check("random_drained", s_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
